// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared defaults, FSM state type and saturating adder for the SAD PE.
package me_pkg;

  localparam int ME_PIX_W  = 8;
  localparam int ME_ACC_W  = 16;
  localparam int ME_CAND_W = 8;
  localparam int ME_MAX_W  = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } me_pe_state_t;

  // Operands are below 2**w; the MSB of the result is the saturation flag.
  function automatic logic [ME_MAX_W:0] me_sat_add(
    input logic [ME_MAX_W-1:0] a,
    input logic [ME_MAX_W-1:0] b,
    input int                  w
  );
    logic [ME_MAX_W:0] sum;
    logic [ME_MAX_W:0] ones;
    sum  = {1'b0, a} + {1'b0, b};
    ones = ((ME_MAX_W+1)'(1) << w) - (ME_MAX_W+1)'(1);
    if ((sum >> w) != '0) begin
      return {1'b1, ones[ME_MAX_W-1:0]};
    end
    return {1'b0, sum[ME_MAX_W-1:0]};
  endfunction

endpackage

// File: rtl/me_absdiff.sv
// rtl/me_absdiff.sv - search-pixel select and unsigned absolute difference.
module me_absdiff #(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] r,
  input  logic [PIX_W-1:0] s1,
  input  logic [PIX_W-1:0] s2,
  input  logic             s1s2mux,
  output logic [PIX_W-1:0] d
);

  logic [PIX_W-1:0] sel;
  logic [PIX_W:0]   diff;
  logic [PIX_W:0]   neg;

  always_comb begin
    sel  = s1s2mux ? s1 : s2;
    diff = {1'b0, r} - {1'b0, sel};
    neg  = -diff;
    d    = diff[PIX_W] ? neg[PIX_W-1:0] : diff[PIX_W-1:0];
  end

endmodule

// File: rtl/me_sad_pe.sv
// rtl/me_sad_pe.sv - SAD processing element with per-candidate counter and best-match tracker.
module me_sad_pe
  import me_pkg::*;
#(
  parameter int PIX_W   = ME_PIX_W,
  parameter int ACC_W   = ME_ACC_W,
  parameter int BLK_PIX = 256,
  parameter int CAND_W  = ME_CAND_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [PIX_W-1:0]  r,
  input  logic [PIX_W-1:0]  s1,
  input  logic [PIX_W-1:0]  s2,
  input  logic              s1s2mux,
  input  logic              newdist,
  input  logic [CAND_W-1:0] cand_id,
  input  logic              clear_best,
  output logic [PIX_W-1:0]  rpipe,
  output logic              rpipe_valid,
  output logic [ACC_W-1:0]  accumulate,
  output logic              sad_valid,
  output logic [ACC_W-1:0]  sad,
  output logic [CAND_W-1:0] sad_cand,
  output logic              sad_sat,
  output logic [ACC_W-1:0]  best_sad,
  output logic [CAND_W-1:0] best_cand,
  output logic              best_valid
);

  localparam int CNT_W = $clog2(BLK_PIX + 1);

  me_pe_state_t      state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ACC_W-1:0]  acc_n;
  logic [CAND_W-1:0] cand_lat, cand_n;
  logic              sat, sat_n;
  logic              done;
  logic [PIX_W-1:0]  d;
  logic [ACC_W-1:0]  d_ext;
  logic [ME_MAX_W:0] add_res;
  logic              bv_c, best_valid_n;
  logic [ACC_W-1:0]  bs_c, best_sad_n;
  logic [CAND_W-1:0] bc_c, best_cand_n;

  me_absdiff #(.PIX_W(PIX_W)) u_absdiff (
    .r       (r),
    .s1      (s1),
    .s2      (s2),
    .s1s2mux (s1s2mux),
    .d       (d)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc_n   = accumulate;
    cand_n  = cand_lat;
    sat_n   = sat;
    done    = 1'b0;
    d_ext   = ACC_W'(d);
    add_res = me_sat_add(ME_MAX_W'(accumulate), ME_MAX_W'(d_ext), ACC_W);
    if (in_valid) begin
      if (newdist) begin
        // A newdist mid-candidate drops the partial and restarts here.
        acc_n  = d_ext;
        cnt_n  = CNT_W'(1);
        cand_n = cand_id;
        sat_n  = 1'b0;
        if (BLK_PIX == 1) begin
          done    = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = ACCUM;
        end
      end else if (state == ACCUM) begin
        acc_n = add_res[ACC_W-1:0];
        sat_n = sat | add_res[ME_MAX_W];
        cnt_n = cnt + CNT_W'(1);
        if (cnt_n == CNT_W'(BLK_PIX)) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
    end

    // The clear takes effect before a coincident result is compared.
    bv_c         = clear_best ? 1'b0 : best_valid;
    bs_c         = clear_best ? '1 : best_sad;
    bc_c         = clear_best ? '0 : best_cand;
    best_valid_n = bv_c;
    best_sad_n   = bs_c;
    best_cand_n  = bc_c;
    if (done && (!bv_c || (acc_n < bs_c))) begin
      best_valid_n = 1'b1;
      best_sad_n   = acc_n;
      best_cand_n  = cand_n;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      accumulate  <= '0;
      cand_lat    <= '0;
      sat         <= 1'b0;
      rpipe       <= '0;
      rpipe_valid <= 1'b0;
      sad_valid   <= 1'b0;
      sad         <= '0;
      sad_cand    <= '0;
      sad_sat     <= 1'b0;
      best_sad    <= '1;
      best_cand   <= '0;
      best_valid  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      accumulate  <= acc_n;
      cand_lat    <= cand_n;
      sat         <= sat_n;
      rpipe       <= r;
      rpipe_valid <= in_valid;
      sad_valid   <= done;
      if (done) begin
        sad      <= acc_n;
        sad_cand <= cand_n;
        sad_sat  <= sat_n;
      end
      best_sad   <= best_sad_n;
      best_cand  <= best_cand_n;
      best_valid <= best_valid_n;
    end
  end

endmodule
